// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI master that sends a command frame then a data frame.
// Define SPI_CMD_READBACK_EN to build the miso capture of the data frame.
module spi_cmd_master #(
  parameter int HALF_PERIOD = 5,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic [7:0] data_byte,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DW = $clog2(HALF_PERIOD);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    TAIL  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div, div_n;
  logic [3:0]    half, half_n;
  logic [GW-1:0] gap, gap_n;
  logic          second, second_n;
  logic [15:0]   tx, tx_n;
  logic          ss_nx, sclk_nx, mosi_nx;
  logic          busy_nx, rsp_valid_nx;
  logic          fall, finish;

  assign cmd_ready = (state == IDLE);

  // state, counters and registered SPI pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div       <= '0;
      half      <= '0;
      gap       <= '0;
      second    <= 1'b0;
      tx        <= '0;
      ss        <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= div_n;
      half      <= half_n;
      gap       <= gap_n;
      second    <= second_n;
      tx        <= tx_n;
      ss        <= ss_nx;
      sclk      <= sclk_nx;
      mosi      <= mosi_nx;
      busy      <= busy_nx;
      rsp_valid <= rsp_valid_nx;
    end
  end

  // sequencing of both frames; tx holds {cmd,data} and shifts across frames
  always_comb begin
    state_n      = state;
    div_n        = div;
    half_n       = half;
    gap_n        = gap;
    second_n     = second;
    tx_n         = tx;
    ss_nx        = ss;
    sclk_nx      = sclk;
    mosi_nx      = mosi;
    rsp_valid_nx = 1'b0;
    fall         = 1'b0;
    finish       = 1'b0;
    unique case (state)
      IDLE: begin
        mosi_nx = 1'b0;
        if (cmd_valid) begin
          state_n  = SETUP;
          div_n    = '0;
          second_n = 1'b0;
          tx_n     = {cmd_byte, data_byte};
          ss_nx    = 1'b1;
        end
      end
      SETUP: begin
        if (div == DIV_LAST) begin
          state_n = SHIFT;
          div_n   = '0;
          half_n  = '0;
          sclk_nx = 1'b1;
          mosi_nx = tx[15];
          tx_n    = {tx[14:0], 1'b0};
        end else begin
          div_n = div + 1'b1;
        end
      end
      SHIFT: begin
        if (div == DIV_LAST) begin
          div_n = '0;
          if (half == 4'd15) begin
            state_n = TAIL;
          end else begin
            half_n  = half + 4'd1;
            sclk_nx = ~sclk;
            if (sclk) begin
              fall = 1'b1;
            end else begin
              mosi_nx = tx[15];
              tx_n    = {tx[14:0], 1'b0};
            end
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      TAIL: begin
        if (div == DIV_LAST) begin
          div_n   = '0;
          ss_nx   = 1'b0;
          mosi_nx = 1'b0;
          if (second) begin
            state_n      = DONE;
            finish       = 1'b1;
            rsp_valid_nx = 1'b1;
          end else begin
            state_n = GAP;
            gap_n   = '0;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      GAP: begin
        if (gap == GAP_LAST) begin
          state_n  = SETUP;
          div_n    = '0;
          second_n = 1'b1;
          ss_nx    = 1'b1;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_nx = (state_n != IDLE);
  end

`ifdef SPI_CMD_READBACK_EN
  logic [7:0] rx, rsp_q;

  // miso captured on sclk falling edges; frame-2 byte kept as response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx    <= '0;
      rsp_q <= '0;
    end else begin
      if (fall) rx <= {rx[6:0], miso};
      if (finish) rsp_q <= rx;
    end
  end

  assign rsp_data = rsp_q;
`else
  logic unused_rx;
  assign unused_rx = miso ^ fall ^ finish;
  assign rsp_data  = 8'h00;
`endif

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed and random transfers on two parameter sets,
// checked against a frame-level model driven by a byte-level SPI slave.
module tb_spi_cmd_master;

  localparam int HP0 = 5;
  localparam int GP0 = 4;
  localparam int HP1 = 2;
  localparam int GP1 = 1;

  typedef struct {
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] r;
  } txn_t;

  typedef struct {
    int acc;
    int rsp;
    int fl;
    int gl;
    int rc;
    int bt;
    int bad;
  } base_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [7:0] cmd_byte  [2];
  logic [7:0] data_byte [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       busy      [2];
  logic       ss        [2];
  logic       sclk      [2];
  logic       mosi      [2];
  logic       miso      [2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // observations gathered by the monitor
  int         acc_q     [2][$];
  int         rsp_cyc_q [2][$];
  logic [7:0] rsp_dat_q [2][$];
  int         fl_q      [2][$];
  int         gl_q      [2][$];
  int         rc_q      [2][$];
  logic       bit_q     [2][$];
  int         rdy_bad   [2];

  // slave bytes per frame of the current transaction, set by the stimulus
  logic [7:0] slv_b [2][2];
  txn_t       exp_q [$];

  logic       p_ss     [2];
  logic       p_sclk   [2];
  int         hi_run   [2];
  int         lo_run   [2];
  int         rise_cnt [2];
  logic [2:0] slv_bit  [2];
  logic [7:0] slv_byte [2];

  spi_cmd_master #(.HALF_PERIOD(HP0), .GAP_CYCLES(GP0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_byte(cmd_byte[0]), .data_byte(data_byte[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .ss(ss[0]), .sclk(sclk[0]),
    .mosi(mosi[0]), .miso(miso[0])
  );

  spi_cmd_master #(.HALF_PERIOD(HP1), .GAP_CYCLES(GP1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_byte(cmd_byte[1]), .data_byte(data_byte[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .ss(ss[1]), .sclk(sclk[1]),
    .mosi(mosi[1]), .miso(miso[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave and waveform monitor, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        p_ss[i]     = 1'b0;
        p_sclk[i]   = 1'b0;
        hi_run[i]   = 0;
        lo_run[i]   = 0;
        rise_cnt[i] = 0;
        slv_bit[i]  = 3'd0;
        slv_byte[i] = 8'h00;
        miso[i]     = 1'b0;
      end else begin
        if (cmd_valid[i] && cmd_ready[i]) acc_q[i].push_back(cyc);
        if (busy[i] && cmd_ready[i]) rdy_bad[i]++;
        if (p_ss[i] && !ss[i]) begin
          fl_q[i].push_back(hi_run[i]);
          rc_q[i].push_back(rise_cnt[i]);
          hi_run[i] = 0;
        end
        if (!p_ss[i] && ss[i]) begin
          slv_byte[i] = (lo_run[i] > 0) ? slv_b[i][1] : slv_b[i][0];
          if (lo_run[i] > 0) gl_q[i].push_back(lo_run[i]);
          lo_run[i]   = 0;
          rise_cnt[i] = 0;
          slv_bit[i]  = 3'd0;
        end
        if (ss[i]) hi_run[i]++;
        if (!busy[i]) lo_run[i] = 0;
        else if (!ss[i]) lo_run[i]++;
        if (sclk[i] && !p_sclk[i]) begin
          bit_q[i].push_back(mosi[i]);
          rise_cnt[i]++;
          miso[i] = slv_byte[i][3'd7 - slv_bit[i]];
          slv_bit[i] = slv_bit[i] + 3'd1;
        end
        if (rsp_valid[i]) begin
          rsp_cyc_q[i].push_back(cyc);
          rsp_dat_q[i].push_back(rsp_data[i]);
        end
        p_ss[i]   = ss[i];
        p_sclk[i] = sclk[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hp_of(input int i);
    return (i == 0) ? HP0 : HP1;
  endfunction

  function automatic int gp_of(input int i);
    return (i == 0) ? GP0 : GP1;
  endfunction

  function automatic base_t snap(input int i);
    base_t b;
    b.acc = acc_q[i].size();
    b.rsp = rsp_cyc_q[i].size();
    b.fl  = fl_q[i].size();
    b.gl  = gl_q[i].size();
    b.rc  = rc_q[i].size();
    b.bt  = bit_q[i].size();
    b.bad = rdy_bad[i];
    return b;
  endfunction

  task automatic wait_rsp(input int i, input int target);
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (rsp_cyc_q[i].size() >= target) break;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // compare everything recorded since b against the transactions in exp_q
  task automatic verify(input int i, input base_t b, input bit b2b);
    int n;
    int hp;
    int g;
    logic [15:0] w;
    logic [7:0]  er;
    n  = exp_q.size();
    hp = hp_of(i);
    g  = gp_of(i);
    chk("accepts", acc_q[i].size() - b.acc, n);
    chk("responses", rsp_cyc_q[i].size() - b.rsp, n);
    chk("frames", fl_q[i].size() - b.fl, 2 * n);
    chk("gaps", gl_q[i].size() - b.gl, n);
    chk("mosi_bits", bit_q[i].size() - b.bt, 16 * n);
    chk("ready_in_busy", rdy_bad[i] - b.bad, 0);
    for (int k = 0; k < n; k++) begin
`ifdef SPI_CMD_READBACK_EN
      er = exp_q[k].r;
`else
      er = 8'h00;
`endif
      if (acc_q[i].size() > b.acc + k && rsp_cyc_q[i].size() > b.rsp + k)
        chk("latency", rsp_cyc_q[i][b.rsp + k] - acc_q[i][b.acc + k],
            36 * hp + g + 1);
      if (rsp_dat_q[i].size() > b.rsp + k)
        chk("rsp_data", rsp_dat_q[i][b.rsp + k], er);
      if (b2b && k > 0 && acc_q[i].size() > b.acc + k)
        chk("b2b_accept", acc_q[i][b.acc + k] - rsp_cyc_q[i][b.rsp + k - 1], 1);
      if (gl_q[i].size() > b.gl + k)
        chk("gap_len", gl_q[i][b.gl + k], g);
      for (int f = 0; f < 2; f++) begin
        if (fl_q[i].size() > b.fl + 2 * k + f)
          chk("frame_len", fl_q[i][b.fl + 2 * k + f], 18 * hp);
        if (rc_q[i].size() > b.rc + 2 * k + f)
          chk("sclk_rises", rc_q[i][b.rc + 2 * k + f], 8);
      end
      if (bit_q[i].size() >= b.bt + 16 * (k + 1)) begin
        w = '0;
        for (int j = 0; j < 16; j++)
          w = {w[14:0], bit_q[i][b.bt + 16 * k + j]};
        chk("mosi_word", w, {exp_q[k].c, exp_q[k].d});
      end
    end
  endtask

  task automatic run(input int i, input logic [7:0] c, input logic [7:0] d,
                     input logic [7:0] r, input logic [7:0] r1);
    base_t b;
    b = snap(i);
    exp_q.delete();
    exp_q.push_back('{c: c, d: d, r: r});
    slv_b[i][0] = r1;
    slv_b[i][1] = r;
    @(posedge clk); #1;
    cmd_byte[i]  = c;
    data_byte[i] = d;
    cmd_valid[i] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    cmd_byte[i]  = 8'($urandom);
    data_byte[i] = 8'($urandom);
    wait_rsp(i, b.rsp + 1);
    verify(i, b, 1'b0);
  endtask

  task automatic back_to_back(input int i);
    base_t b;
    txn_t  t0;
    txn_t  t1;
    b  = snap(i);
    t0 = '{c: 8'h3C, d: 8'hC3, r: 8'hA5};
    t1 = '{c: 8'h81, d: 8'h7E, r: 8'h96};
    exp_q.delete();
    exp_q.push_back(t0);
    exp_q.push_back(t1);
    slv_b[i][0] = 8'h11;
    slv_b[i][1] = t0.r;
    @(posedge clk); #1;
    cmd_byte[i]  = t0.c;
    data_byte[i] = t0.d;
    cmd_valid[i] = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (acc_q[i].size() >= b.acc + 1) break;
    end
    cmd_byte[i]  = t1.c;
    data_byte[i] = t1.d;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (rsp_cyc_q[i].size() >= b.rsp + 1) break;
    end
    slv_b[i][1] = t1.r;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (acc_q[i].size() >= b.acc + 2) break;
    end
    cmd_valid[i] = 1'b0;
    wait_rsp(i, b.rsp + 2);
    verify(i, b, 1'b1);
  endtask

  task automatic reset_mid(input int i);
    base_t b;
    int    nss;
    int    nr;
    logic  pss;
    logic  psc;
    logic  hit;
    b   = snap(i);
    nss = 0;
    nr  = 0;
    pss = 1'b0;
    psc = 1'b0;
    hit = 1'b0;
    slv_b[i][0] = 8'hF0;
    slv_b[i][1] = 8'h0F;
    @(posedge clk); #1;
    cmd_byte[i]  = 8'h80;
    data_byte[i] = 8'h00;
    cmd_valid[i] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (ss[i] && !pss) begin
        nss++;
        nr = 0;
      end
      if (sclk[i] && !psc) nr++;
      pss = ss[i];
      psc = sclk[i];
      if (nss == 2 && nr == 4) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("abort_point_reached", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_ss", ss[i], 1'b0);
    chk("abort_sclk", sclk[i], 1'b0);
    chk("abort_busy", busy[i], 1'b0);
    chk("abort_ready", cmd_ready[i], 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_rsp", rsp_cyc_q[i].size() - b.rsp, 0);
    chk("abort_rsp_valid", rsp_valid[i], 1'b0);
    run(i, 8'h80, 8'h00, 8'hFF, 8'hFF);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_byte[i]  = 8'h00;
      data_byte[i] = 8'h00;
      rdy_bad[i]   = 0;
      slv_b[i][0]  = 8'h00;
      slv_b[i][1]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("ready_in_reset", cmd_ready[i], 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ss", ss[i], 1'b0);
      chk("rst_sclk", sclk[i], 1'b0);
      chk("rst_mosi", mosi[i], 1'b0);
      chk("rst_ready", cmd_ready[i], 1'b1);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_rsp_valid", rsp_valid[i], 1'b0);
      chk("rst_rsp_data", rsp_data[i], 8'h00);
    end

    run(0, 8'h80, 8'h00, 8'hFF, 8'hFF);
    run(0, 8'h9B, 8'hAA, 8'h5C, 8'h33);
    back_to_back(0);
    reset_mid(0);

    run(1, 8'h80, 8'h00, 8'hFF, 8'hFF);
    run(1, 8'h9B, 8'hAA, 8'h5C, 8'h33);
    back_to_back(1);

    for (int k = 0; k < 6; k++)
      run(k % 2, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
